// File: rtl/regfile_write_arbiter.sv
// Single write port of the 32x32 register file, shared between writeback (priority)
// and the multi-cycle unit, plus a sequenced clear of x1..x31.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ready,
    input  logic                  mc_valid,
    input  logic [4:0]            mc_addr,
    input  logic [DATA_WIDTH-1:0] mc_data,
    output logic                  mc_ready,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  rf_write_enable,
    output logic [4:0]            rf_write_address,
    output logic [DATA_WIDTH-1:0] rf_write_data
);
    typedef enum logic {ST_ARB, ST_CLEAR} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [4:0] LAST_REG   = 5'd31;

    state_t                  state_q, state_d;
    logic [4:0]              clr_cnt_q, clr_cnt_d;
    logic [3:0]              starve_q, starve_d;
    logic                    rf_we_q, rf_we_d;
    logic [4:0]              rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]   rf_data_q, rf_data_d;
    logic                    clear_done_q, clear_done_d;
    logic                    wb_grant, mc_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_ARB;
            clr_cnt_q    <= '0;
            starve_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            starve_q     <= starve_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            clear_done_q <= clear_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = 5'd1;
                end
            end
            ST_CLEAR: begin
                // Counter wraps to 0 after x31, matching its idle value.
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == LAST_REG) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // A starved MC request beats WB; otherwise WB has priority.
    always_comb begin
        wb_grant = 1'b0;
        mc_grant = 1'b0;
        if (state_q == ST_ARB && !clear_start) begin
            if (starve_q == STARVE_MAX && mc_valid) begin
                mc_grant = 1'b1;
            end else if (wb_valid) begin
                wb_grant = 1'b1;
            end else if (mc_valid) begin
                mc_grant = 1'b1;
            end
        end
    end

    always_comb begin
        rf_we_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;
        clear_done_d = 1'b0;
        starve_d     = starve_q;
        if (state_q == ST_CLEAR) begin
            rf_we_d      = 1'b1;
            rf_addr_d    = clr_cnt_q;
            rf_data_d    = '0;
            clear_done_d = (clr_cnt_q == LAST_REG);
        end else begin
            // Writes to x0 are accepted but never reach the register file.
            if (wb_grant && wb_addr != 5'd0) begin
                rf_we_d   = 1'b1;
                rf_addr_d = wb_addr;
                rf_data_d = wb_data;
            end else if (mc_grant && mc_addr != 5'd0) begin
                rf_we_d   = 1'b1;
                rf_addr_d = mc_addr;
                rf_data_d = mc_data;
            end
            if (!mc_valid || mc_grant) begin
                starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    assign wb_ready         = wb_grant;
    assign mc_ready         = mc_grant;
    assign clear_busy       = (state_q == ST_CLEAR);
    assign clear_done       = clear_done_q;
    assign rf_write_enable  = rf_we_q;
    assign rf_write_address = rf_addr_q;
    assign rf_write_data    = rf_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: literal checks per scenario plus a
// per-cycle reference model of arbitration, starvation and clear sequencing.
module tb_regfile_write_arbiter;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid, mc_valid, clear_start;
    logic [4:0]  wb_addr, mc_addr;
    logic [31:0] wb_data, mc_data;
    logic        wb_ready, mc_ready, clear_busy, clear_done;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
        .rf_write_data(rf_write_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reference model: state advanced at each falling edge, after comparing.
    bit          model_ok = 0;
    bit          m_clearing = 0, m_done = 0, m_we = 0;
    int          m_next = 0, m_wait = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_data = 0;

    always @(negedge clock) begin
        bit e_wb, e_mc;
        logic [4:0] a;
        logic [31:0] d;
        e_wb = 0;
        e_mc = 0;
        if (!m_clearing && !clear_start) begin
            if (m_wait == LIMIT && mc_valid) e_mc = 1;
            else if (wb_valid) e_wb = 1;
            else if (mc_valid) e_mc = 1;
        end
        if (model_ok) begin
            chk("m_wb_ready", 32'(wb_ready), 32'(e_wb));
            chk("m_mc_ready", 32'(mc_ready), 32'(e_mc));
            chk("m_rf_we", 32'(rf_write_enable), 32'(m_we));
            chk("m_rf_addr", 32'(rf_write_address), 32'(m_addr));
            chk("m_rf_data", rf_write_data, m_data);
            chk("m_busy", 32'(clear_busy), 32'(m_clearing));
            chk("m_done", 32'(clear_done), 32'(m_done));
        end
        if (reset) begin
            m_clearing = 0; m_done = 0; m_we = 0; m_next = 0; m_wait = 0;
            m_addr = 0; m_data = 0;
            model_ok = 1;
        end else begin
            m_done = 0;
            m_we = 0;
            if (m_clearing) begin
                m_we = 1;
                m_addr = 5'(m_next);
                m_data = 0;
                if (m_next == 31) begin
                    m_clearing = 0;
                    m_done = 1;
                end
                m_next++;
            end else begin
                if (e_wb || e_mc) begin
                    a = e_wb ? wb_addr : mc_addr;
                    d = e_wb ? wb_data : mc_data;
                    if (a != 0) begin
                        m_we = 1;
                        m_addr = a;
                        m_data = d;
                    end
                end
                if (e_mc || !mc_valid) m_wait = 0;
                else if (m_wait < LIMIT) m_wait++;
                if (clear_start) begin
                    m_clearing = 1;
                    m_next = 1;
                end
            end
        end
    end

    // Runs one clear with WB pending; optionally re-pulses clear_start mid-sequence.
    task automatic run_clear(input int repulse_at);
        int exp_a;
        bit got_done;
        wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h55; mc_valid = 0; clear_start = 1;
        @(negedge clock);
        chk("clr_start_wb_ready", 32'(wb_ready), 0);
        cyc();
        clear_start = 0;
        exp_a = 1;
        got_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (rf_write_enable) begin
                chk("clr_addr", 32'(rf_write_address), 32'(exp_a));
                chk("clr_data", rf_write_data, 0);
                exp_a++;
            end
            if (clear_done) begin
                got_done = 1;
                chk("done_wb_ready", 32'(wb_ready), 1);
                break;
            end
            chk("clr_wb_ready", 32'(wb_ready), 0);
            chk("clr_busy", 32'(clear_busy), 1);
            cyc();
            clear_start = (n == repulse_at);
        end
        chk("clr_write_count", 32'(exp_a - 1), 31);
        chk("clr_done_seen", 32'(got_done), 1);
        cyc();
        wb_valid = 0; clear_start = 0;
        @(negedge clock);
        chk("post_clr_done", 32'(clear_done), 0);
        chk("post_clr_busy", 32'(clear_busy), 0);
        chk("post_clr_wb_we", 32'(rf_write_enable), 1);
        chk("post_clr_wb_addr", 32'(rf_write_address), 9);
        chk("post_clr_wb_data", rf_write_data, 32'h55);
        $display("clear sequence done: writes=%0d repulse_at=%0d", exp_a - 1, repulse_at);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc_wb, acc_mc, seen10;
        reset = 1; wb_valid = 0; mc_valid = 0; clear_start = 0;
        wb_addr = 0; wb_data = 0; mc_addr = 0; mc_data = 0;
        cyc(); cyc();
        reset = 0;
        @(negedge clock);
        chk("rst_we", 32'(rf_write_enable), 0);
        chk("rst_addr", 32'(rf_write_address), 0);
        chk("rst_data", rf_write_data, 0);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_done", 32'(clear_done), 0);
        $display("reset state checked");
        cyc();

        // Single WB write
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        @(negedge clock);
        chk("wb1_ready", 32'(wb_ready), 1);
        chk("wb1_mc_ready", 32'(mc_ready), 0);
        cyc();
        wb_valid = 0;
        @(negedge clock);
        chk("wb1_we", 32'(rf_write_enable), 1);
        chk("wb1_addr", 32'(rf_write_address), 5);
        chk("wb1_data", rf_write_data, 32'hDEADBEEF);
        cyc();
        @(negedge clock);
        chk("wb1_we_drop", 32'(rf_write_enable), 0);
        $display("single WB write addr=5 data=deadbeef");
        cyc();

        // Both valid: MC starves for LIMIT cycles, then wins one
        wb_valid = 1; wb_addr = 5'd3; wb_data = 32'hAAAA0003;
        mc_valid = 1; mc_addr = 5'd7; mc_data = 32'hBBBB0007;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("starve_wb_ready", 32'(wb_ready), 32'(i < 4));
            chk("starve_mc_ready", 32'(mc_ready), 32'(i == 4));
            cyc();
        end
        wb_valid = 0; mc_valid = 0;
        @(negedge clock);
        chk("starve_mc_we", 32'(rf_write_enable), 1);
        chk("starve_mc_addr", 32'(rf_write_address), 7);
        chk("starve_mc_data", rf_write_data, 32'hBBBB0007);
        cyc();
        wb_valid = 1; mc_valid = 1;
        @(negedge clock);
        chk("starve_reset_wb_ready", 32'(wb_ready), 1);
        $display("starvation: MC granted after %0d WB grants", LIMIT);
        cyc();
        wb_valid = 0; mc_valid = 0;
        cyc();

        // x0 write
        wb_valid = 1; wb_addr = 5'd0; wb_data = 32'h1234;
        @(negedge clock);
        chk("x0_ready", 32'(wb_ready), 1);
        cyc();
        wb_valid = 0;
        @(negedge clock);
        chk("x0_we", 32'(rf_write_enable), 0);
        chk("x0_addr_hold", 32'(rf_write_address), 3);
        $display("x0 write suppressed");
        cyc();

        run_clear(-1);
        run_clear(5);

        // Reset in the middle of a clear
        clear_start = 1;
        cyc();
        clear_start = 0;
        seen10 = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (rf_write_enable && rf_write_address == 5'd10) begin
                seen10 = 1;
                break;
            end
            cyc();
        end
        chk("midclr_reached_10", 32'(seen10), 1);
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        @(negedge clock);
        chk("midrst_we", 32'(rf_write_enable), 0);
        chk("midrst_addr", 32'(rf_write_address), 0);
        chk("midrst_data", rf_write_data, 0);
        chk("midrst_busy", 32'(clear_busy), 0);
        chk("midrst_done", 32'(clear_done), 0);
        for (int n = 0; n < 3; n++) begin
            cyc();
            @(negedge clock);
            chk("midrst_no_done", 32'(clear_done), 0);
        end
        $display("reset mid-clear abandoned sequence");
        cyc();
        run_clear(-1);

        // Mixed traffic; requests held until accepted
        acc_wb = 0; acc_mc = 0;
        for (int n = 0; n < 300; n++) begin
            if (!wb_valid || acc_wb) begin
                wb_valid = ($urandom_range(0, 3) != 0);
                wb_addr = 5'($urandom_range(0, 31));
                wb_data = $urandom;
            end
            if (!mc_valid || acc_mc) begin
                mc_valid = ($urandom_range(0, 2) != 0);
                mc_addr = 5'($urandom_range(0, 31));
                mc_data = $urandom;
            end
            clear_start = ($urandom_range(0, 59) == 0);
            @(negedge clock);
            acc_wb = wb_ready;
            acc_mc = mc_ready;
            cyc();
        end
        wb_valid = 0; mc_valid = 0; clear_start = 0;
        repeat (40) cyc();
        $display("mixed traffic phase complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 integer register file.
- Shares the port between two requesters:
  - the pipeline writeback stage (WB), priority requester;
  - the long-latency multi-cycle unit (MC), secondary requester.
- Also sequences a software/debug-triggered clear that zeroes x1..x31, one register per cycle.
- Drives the register file's WriteEnable/write_address/write_data_in from registered outputs.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles MC may wait (valid, not accepted) before it is granted over WB; legal range 1..15.
- DATA_WIDTH, 32: register data width.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  WB write request.
- wb_addr  in  5  WB destination register.
- wb_data  in  DATA_WIDTH  WB write data.
- wb_ready  out  1  WB request accepted this cycle (combinational).
- mc_valid  in  1  MC write request.
- mc_addr  in  5  MC destination register.
- mc_data  in  DATA_WIDTH  MC write data.
- mc_ready  out  1  MC request accepted this cycle (combinational).
- clear_start  in  1  single-cycle pulse: begin clear sequence.
- clear_busy  out  1  high while clearing.
- clear_done  out  1  one-cycle pulse after the last clear write is issued.
- rf_write_enable  out  1  to register file WriteEnable.
- rf_write_address  out  5  to register file write_address.
- rf_write_data  out  DATA_WIDTH  to register file write_data_in.

Behaviour:
- Reset values:
  - rf_write_enable=0, rf_write_address=0, rf_write_data=0.
  - clear_busy=0, clear_done=0.
  - state=ARB, clear counter=0, starve counter=0.
  - Reset overrides everything, including mid-clear; the clear is abandoned with no clear_done pulse.
- Handshake:
  - A request is accepted in the cycle where valid&ready=1.
  - The accepted write appears on rf_* exactly one cycle later (latency 1), with rf_write_enable high for that single cycle.
  - A requester holds valid/addr/data stable until accepted. ready never depends on the requester's own addr/data.
- State ARB:
  - If clear_start=1: go to CLEAR. Both readies are 0 that cycle; clear_start takes precedence over pending requests.
  - Else if the starve counter equals STARVE_LIMIT and mc_valid=1: mc_ready=1, wb_ready=0.
  - Else if wb_valid=1: wb_ready=1, mc_ready=0.
  - Else if mc_valid=1: mc_ready=1.
  - At most one ready is high in any cycle.
- Starve counter:
  - +1 each cycle mc_valid=1 and mc_ready=0, saturating at STARVE_LIMIT.
  - Cleared on MC acceptance, or when mc_valid=0.
- x0 writes:
  - Accepted normally (ready asserted, counters updated).
  - Next-cycle rf_write_enable=0, so no write is issued.
- Same address from both requesters in one cycle: only the grantee is written; the other waits. No merging.
- State CLEAR:
  - Counter starts at 1 on entry. wb_ready=mc_ready=0.
  - Each cycle: issue a write of address=counter, data=0 (appears on rf_* the next cycle); counter +1.
  - After address 31 is issued: return to ARB next cycle and pulse clear_done one cycle. clear_busy falls in that same cycle.
  - clear_busy is high from the cycle after clear_start through the last write cycle, i.e. 31 cycles.
  - clear_start while already in CLEAR is ignored. The starve counter holds during CLEAR.
- Idle cycles: rf_write_enable=0. rf_write_address/rf_write_data hold their last values.

Test Plan:
- Reset then single WB write: wb_valid=1, addr=5, data=0xDEADBEEF → wb_ready=1 same cycle; next cycle rf_write_enable=1, addr=5, data=0xDEADBEEF; following cycle rf_write_enable=0.
- Both valid continuously (WB addr=3, MC addr=7, STARVE_LIMIT=4) → WB granted cycles 0–3; MC granted in cycle 4; MC data appears on rf_* in cycle 5; starve counter returns to 0.
- x0 write: WB addr=0, data=0x1234 → wb_ready=1; next cycle rf_write_enable=0.
- Clear: clear_start pulse with wb_valid=1 held → 31 consecutive writes with addresses 1..31, data 0; wb_ready=0 throughout; clear_done pulses once; WB is accepted in the cycle clear_done is high.
- Reset asserted mid-clear (after address 10 is issued) → next cycle all outputs are at reset values; no clear_done pulse; the following clear_start restarts at address 1.
- clear_start re-pulsed during CLEAR → sequence unchanged: still exactly 31 writes and one clear_done.
